// File: rtl/regfile_pkg.sv
// Shared constants, FSM state type and one-hot helper for the register-file
// access scheduler.
package regfile_pkg;

    localparam int NREG  = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FORCE = 2'd2
    } state_e;

    function automatic logic [NREG-1:0] onehot16(input logic [IDX_W-1:0] idx);
        onehot16 = {{(NREG-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rf_onehot_dec.sv
// Register index to one-hot row enable decoder; an idle port drives no row.
module rf_onehot_dec
    import regfile_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [NREG-1:0]  row
);

    assign row = en ? onehot16(idx) : {NREG{1'b0}};

endmodule

// File: rtl/regfile_sched.sv
// Register-file access scheduler: post-reset zero-fill sweep, pipeline decode,
// and opportunistic debug access with a bounded-starvation forced slot.
module regfile_sched
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  cpu_src1,
    input  logic [IDX_W-1:0]  cpu_src2,
    input  logic              cpu_rd1_en,
    input  logic              cpu_rd2_en,
    input  logic [IDX_W-1:0]  cpu_dst,
    input  logic              cpu_wr_en,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic [NREG-1:0]   wr_row,
    output logic [NREG-1:0]   rd1_row,
    output logic [NREG-1:0]   rd2_row,
    output logic [15:0]       wdata,
    input  logic [15:0]       rdata2,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [IDX_W-1:0]  dbg_reg,
    input  logic [15:0]       dbg_wdata,
    output logic              dbg_ack,
    output logic [15:0]       dbg_rdata,
    output logic              init_done
);

    localparam logic [8:0] LIMIT_C = 9'(STARVE_LIMIT);

    state_e             state_r;
    logic [IDX_W-1:0]   init_cnt_r;
    logic [7:0]         starve_r;
    logic               init_done_r;
    logic               dbg_ack_r;
    logic [15:0]        dbg_rdata_r;

    logic [IDX_W-1:0]   wr_idx_s;
    logic [IDX_W-1:0]   rd1_idx_s;
    logic [IDX_W-1:0]   rd2_idx_s;
    logic               wr_en_s;
    logic               rd1_en_s;
    logic               rd2_en_s;
    logic [15:0]        wdata_s;
    logic               grant_s;
    logic               cpu_wr_ok_s;
    logic [8:0]         starve_inc_s;

    assign cpu_wr_ok_s  = cpu_wr_en && (cpu_dst != 4'd0);
    assign starve_inc_s = {1'b0, starve_r} + 9'd1;

    // Port steering: sweep, pipeline requests, and debug overlay on an idle port.
    always_comb begin
        wr_idx_s  = cpu_dst;
        rd1_idx_s = cpu_src1;
        rd2_idx_s = cpu_src2;
        wr_en_s   = 1'b0;
        rd1_en_s  = 1'b0;
        rd2_en_s  = 1'b0;
        wdata_s   = 16'h0000;
        grant_s   = 1'b0;
        case (state_r)
            INIT: begin
                wr_idx_s = init_cnt_r;
                wr_en_s  = 1'b1;
            end
            RUN: begin
                rd1_en_s = cpu_rd1_en;
                // The ack cycle never grants, so a still-held request cannot reissue.
                grant_s  = dbg_req && !dbg_ack_r && (dbg_we ? !cpu_wr_en : !cpu_rd2_en);
                if (grant_s && dbg_we) begin
                    wr_idx_s = dbg_reg;
                    wr_en_s  = (dbg_reg != 4'd0);
                    wdata_s  = dbg_wdata;
                    rd2_en_s = cpu_rd2_en;
                end else if (grant_s) begin
                    rd2_idx_s = dbg_reg;
                    rd2_en_s  = 1'b1;
                    wr_en_s   = cpu_wr_ok_s;
                    wdata_s   = cpu_wdata;
                end else begin
                    rd2_en_s = cpu_rd2_en;
                    wr_en_s  = cpu_wr_ok_s;
                    wdata_s  = cpu_wdata;
                end
            end
            FORCE: begin
                grant_s = 1'b1;
                if (dbg_we) begin
                    wr_idx_s = dbg_reg;
                    wr_en_s  = (dbg_reg != 4'd0);
                    wdata_s  = dbg_wdata;
                end else begin
                    rd2_idx_s = dbg_reg;
                    rd2_en_s  = 1'b1;
                end
            end
            default: begin
                grant_s = 1'b0;
            end
        endcase
    end

    rf_onehot_dec u_wr_dec  (.idx(wr_idx_s),  .en(wr_en_s  & rst_n), .row(wr_row));
    rf_onehot_dec u_rd1_dec (.idx(rd1_idx_s), .en(rd1_en_s & rst_n), .row(rd1_row));
    rf_onehot_dec u_rd2_dec (.idx(rd2_idx_s), .en(rd2_en_s & rst_n), .row(rd2_row));

    assign wdata     = wdata_s;
    assign cpu_stall = (state_r != RUN);
    assign dbg_ack   = dbg_ack_r;
    assign dbg_rdata = dbg_rdata_r;
    assign init_done = init_done_r;

    // Scheduler FSM, sweep and starvation counters, debug completion registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= INIT;
            init_cnt_r  <= 4'd0;
            starve_r    <= 8'd0;
            init_done_r <= 1'b0;
            dbg_ack_r   <= 1'b0;
            dbg_rdata_r <= 16'h0000;
        end else begin
            dbg_ack_r <= grant_s;
            if (grant_s && !dbg_we) begin
                dbg_rdata_r <= rdata2;
            end else begin
                dbg_rdata_r <= dbg_rdata_r;
            end
            case (state_r)
                INIT: begin
                    init_cnt_r <= init_cnt_r + 4'd1;
                    if (init_cnt_r == 4'd15) begin
                        state_r     <= RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        state_r <= INIT;
                    end
                end
                RUN: begin
                    if (grant_s) begin
                        starve_r <= 8'd0;
                    end else if (dbg_req && !dbg_ack_r) begin
                        starve_r <= starve_inc_s[7:0];
                        if (starve_inc_s >= LIMIT_C) begin
                            state_r <= FORCE;
                        end else begin
                            state_r <= RUN;
                        end
                    end else if (!dbg_req) begin
                        starve_r <= 8'd0;
                    end else begin
                        starve_r <= starve_r;
                    end
                end
                FORCE: begin
                    state_r  <= RUN;
                    starve_r <= 8'd0;
                end
                default: begin
                    state_r <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sched.sv
// Self-checking bench for regfile_sched: directed tables and sequences, then
// random traffic against a cycle-level behavioural model.
module tb_regfile_sched;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cpu_src1, cpu_src2, cpu_dst, dbg_reg;
    logic        cpu_rd1_en, cpu_rd2_en, cpu_wr_en, dbg_req, dbg_we;
    logic [15:0] cpu_wdata, rdata2, dbg_wdata;
    logic        cpu_stall, dbg_ack, init_done;
    logic [15:0] wr_row, rd1_row, rd2_row, wdata, dbg_rdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_sched #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_src1(cpu_src1), .cpu_src2(cpu_src2),
        .cpu_rd1_en(cpu_rd1_en), .cpu_rd2_en(cpu_rd2_en),
        .cpu_dst(cpu_dst), .cpu_wr_en(cpu_wr_en), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .wr_row(wr_row), .rd1_row(rd1_row), .rd2_row(rd2_row),
        .wdata(wdata), .rdata2(rdata2),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_reg(dbg_reg), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .init_done(init_done)
    );

    typedef struct {
        logic [3:0]  s1, s2, d;
        logic        e1, e2, ew;
        logic [15:0] wd, x1, x2, xw;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] oh(input int idx);
        logic [15:0] b;
        b = 16'h0001;
        return b << idx;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_src1 = 4'd0; cpu_src2 = 4'd0; cpu_dst = 4'd0;
        cpu_rd1_en = 1'b0; cpu_rd2_en = 1'b0; cpu_wr_en = 1'b0; cpu_wdata = 16'h0000;
        rdata2 = 16'h0000;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_reg = 4'd0; dbg_wdata = 16'h0000;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_stall"}, {15'd0, cpu_stall}, 16'h0001);
        chk({tag, "_rows"}, wr_row | rd1_row | rd2_row, 16'h0000);
        chk({tag, "_ack"}, {15'd0, dbg_ack}, 16'h0000);
        chk({tag, "_rdata"}, dbg_rdata, 16'h0000);
        chk({tag, "_done"}, {15'd0, init_done}, 16'h0000);
    endtask

    // Release reset (currently asserted) and check the full 16-row zero-fill.
    task automatic sweep_check();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("sweep_row", wr_row, oh(k));
            chk("sweep_wdata", wdata, 16'h0000);
            chk("sweep_stall", {15'd0, cpu_stall}, 16'h0001);
            chk("sweep_done", {15'd0, init_done}, 16'h0000);
            chk("sweep_rd", rd1_row | rd2_row, 16'h0000);
            step();
        end
        @(negedge clk);
        chk("run_done", {15'd0, init_done}, 16'h0001);
        chk("run_stall", {15'd0, cpu_stall}, 16'h0000);
    endtask

    // Behavioural model state for the random phase
    int          m_cyc, m_wait;
    bit          m_run, m_force, m_ack, m_ack_rd, prev_ack, busy, g;
    logic [15:0] m_rdata, e_wr, e_rd1, e_rd2, e_wd;
    bit          e_stall;

    initial begin
        tbl[0] = '{4'd3,  4'd9,  4'd5,  1'b1, 1'b1, 1'b1, 16'hA5A5, 16'h0008, 16'h0200, 16'h0020};
        tbl[1] = '{4'd3,  4'd9,  4'd0,  1'b1, 1'b1, 1'b1, 16'h1111, 16'h0008, 16'h0200, 16'h0000};
        tbl[2] = '{4'd0,  4'd15, 4'd15, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'h8000, 16'h8000};
        tbl[3] = '{4'd7,  4'd7,  4'd1,  1'b0, 1'b1, 1'b1, 16'h0001, 16'h0000, 16'h0080, 16'h0002};
        tbl[4] = '{4'd12, 4'd2,  4'd10, 1'b1, 1'b0, 1'b0, 16'h2222, 16'h1000, 16'h0000, 16'h0000};
        tbl[5] = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[6] = '{4'd14, 4'd1,  4'd8,  1'b1, 1'b1, 1'b1, 16'h8001, 16'h4000, 16'h0002, 16'h0100};

        idle_inputs();
        #12;
        chk_reset_vals("reset");
        sweep_check();

        // Pipeline decode table
        for (int i = 0; i < 7; i++) begin
            step();
            cpu_src1 = tbl[i].s1; cpu_src2 = tbl[i].s2; cpu_dst = tbl[i].d;
            cpu_rd1_en = tbl[i].e1; cpu_rd2_en = tbl[i].e2; cpu_wr_en = tbl[i].ew;
            cpu_wdata = tbl[i].wd;
            @(negedge clk);
            chk("tbl_rd1", rd1_row, tbl[i].x1);
            chk("tbl_rd2", rd2_row, tbl[i].x2);
            chk("tbl_wr", wr_row, tbl[i].xw);
            chk("tbl_wdata", wdata, tbl[i].wd);
            chk("tbl_stall", {15'd0, cpu_stall}, 16'h0000);
        end

        // Opportunistic debug read on idle port 2
        step();
        idle_inputs();
        cpu_rd1_en = 1'b1; cpu_src1 = 4'd2;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_reg = 4'd7; rdata2 = 16'hBEEF;
        @(negedge clk);
        chk("opp_rd2", rd2_row, 16'h0080);
        chk("opp_rd1", rd1_row, 16'h0004);
        chk("opp_stall", {15'd0, cpu_stall}, 16'h0000);
        chk("opp_ack0", {15'd0, dbg_ack}, 16'h0000);
        step();
        dbg_req = 1'b0; rdata2 = 16'h0000;
        @(negedge clk);
        chk("opp_ack", {15'd0, dbg_ack}, 16'h0001);
        chk("opp_rdata", dbg_rdata, 16'hBEEF);
        chk("opp_stall2", {15'd0, cpu_stall}, 16'h0000);
        step();
        @(negedge clk);
        chk("opp_ack_end", {15'd0, dbg_ack}, 16'h0000);

        // Starvation: write port permanently busy
        step();
        idle_inputs();
        cpu_wr_en = 1'b1; cpu_dst = 4'd3; cpu_wdata = 16'h5555;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_reg = 4'd4; dbg_wdata = 16'h1234;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            chk("starve_stall", {15'd0, cpu_stall}, 16'h0000);
            chk("starve_wr", wr_row, 16'h0008);
            chk("starve_ack", {15'd0, dbg_ack}, 16'h0000);
            step();
        end
        @(negedge clk);
        chk("force_stall", {15'd0, cpu_stall}, 16'h0001);
        chk("force_wr", wr_row, 16'h0010);
        chk("force_wdata", wdata, 16'h1234);
        chk("force_rd", rd1_row | rd2_row, 16'h0000);
        step();
        @(negedge clk);
        chk("force_ack", {15'd0, dbg_ack}, 16'h0001);
        chk("force_after_stall", {15'd0, cpu_stall}, 16'h0000);
        chk("force_after_wr", wr_row, 16'h0008);
        step();
        dbg_req = 1'b0;
        @(negedge clk);
        chk("force_ack_end", {15'd0, dbg_ack}, 16'h0000);

        // Reset in a debug grant cycle: no ack may follow
        step();
        idle_inputs();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_reg = 4'd7; rdata2 = 16'hCAFE;
        @(negedge clk);
        chk("mdbg_rd2", rd2_row, 16'h0080);
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("mdbg");
        step();
        chk("mdbg_noack", {15'd0, dbg_ack}, 16'h0000);
        idle_inputs();
        sweep_check();

        // Reset in sweep cycle 6
        rst_n = 1'b0;
        step();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("msw_row", wr_row, oh(k));
            if (k < 6) step();
            else begin
                #1 rst_n = 1'b0;
                #1 chk_reset_vals("msw");
            end
        end
        sweep_check();

        // Random traffic against the model, starting from reset
        step();
        rst_n = 1'b0;
        idle_inputs();
        m_cyc = 0; m_wait = 0; m_run = 0; m_force = 0; m_ack = 0; m_ack_rd = 0;
        prev_ack = 0; m_rdata = 16'h0000;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            busy = ((i / 64) % 2) == 1;
            if (m_ack) begin
                dbg_req = 1'($urandom_range(0, 1));
            end else if (!dbg_req || prev_ack) begin
                dbg_req = ($urandom_range(0, 2) == 0);
                dbg_we = 1'($urandom_range(0, 1));
                dbg_reg = 4'($urandom_range(0, 15));
                dbg_wdata = 16'($urandom);
            end
            cpu_src1 = 4'($urandom_range(0, 15));
            cpu_src2 = 4'($urandom_range(0, 15));
            cpu_dst = 4'($urandom_range(0, 15));
            cpu_rd1_en = 1'($urandom_range(0, 1));
            cpu_rd2_en = busy ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1));
            cpu_wr_en = busy ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1));
            cpu_wdata = 16'($urandom);
            rdata2 = 16'($urandom);

            g = 0; e_rd1 = 16'h0000; e_rd2 = 16'h0000; e_wr = 16'h0000; e_wd = 16'h0000;
            if (!m_run) begin
                e_stall = 1;
                e_wr = oh(m_cyc);
            end else if (m_force) begin
                e_stall = 1;
                g = 1;
                if (dbg_we) begin
                    e_wr = (dbg_reg != 4'd0) ? oh(int'(dbg_reg)) : 16'h0000;
                    e_wd = dbg_wdata;
                end else begin
                    e_rd2 = oh(int'(dbg_reg));
                end
            end else begin
                e_stall = 0;
                e_rd1 = cpu_rd1_en ? oh(int'(cpu_src1)) : 16'h0000;
                e_rd2 = cpu_rd2_en ? oh(int'(cpu_src2)) : 16'h0000;
                e_wr = (cpu_wr_en && cpu_dst != 4'd0) ? oh(int'(cpu_dst)) : 16'h0000;
                e_wd = cpu_wdata;
                g = dbg_req && !m_ack && (dbg_we ? !cpu_wr_en : !cpu_rd2_en);
                if (g && dbg_we) begin
                    e_wr = (dbg_reg != 4'd0) ? oh(int'(dbg_reg)) : 16'h0000;
                    e_wd = dbg_wdata;
                end else if (g) begin
                    e_rd2 = oh(int'(dbg_reg));
                end
            end

            @(negedge clk);
            chk("rnd_stall", {15'd0, cpu_stall}, {15'd0, e_stall});
            chk("rnd_wr", wr_row, e_wr);
            chk("rnd_rd1", rd1_row, e_rd1);
            chk("rnd_rd2", rd2_row, e_rd2);
            chk("rnd_wdata", wdata, e_wd);
            chk("rnd_done", {15'd0, init_done}, {15'd0, m_run});
            chk("rnd_ack", {15'd0, dbg_ack}, {15'd0, m_ack});
            if (m_ack_rd) chk("rnd_rdata", dbg_rdata, m_rdata);

            prev_ack = m_ack;
            if (!m_run) begin
                m_cyc++;
                if (m_cyc == 16) m_run = 1;
                m_wait = 0;
                m_force = 0;
            end else if (g) begin
                m_wait = 0;
                m_force = 0;
            end else if (dbg_req && !m_ack) begin
                m_wait++;
                m_force = (m_wait >= LIMIT);
            end else begin
                if (!dbg_req) m_wait = 0;
                m_force = 0;
            end
            if (g && !dbg_we) m_rdata = rdata2;
            m_ack = g;
            m_ack_rd = g && !dbg_we;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
